hs32_wb_arbiter: RTL and testbench
==================================

# hs32_wb_arbiter

Arbiter and skid buffer for the single register-file write port shared by the execute stage (ALU results) and the load/store unit (load returns). Execute writes take priority. Load returns that lose arbitration are held in a small in-order FIFO and drained on idle write-port cycles. Buffered loads made stale by a younger execute write to the same register are cancelled, and the set of pending load destinations is exported for hazard detection.

## Interface

- `DEPTH`, default 2: load buffer entries; power of two, ≥2.

- `clk` in 1: core clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ex_we_i` in 1: execute stage requests a register write this cycle.
- `ex_addr_i` in 4: execute destination register.
- `ex_data_i` in 32: execute result.
- `ex_stall_o` out 1: execute write not granted; hold the execute stage.
- `ld_vld_i` in 1: load return data valid.
- `ld_addr_i` in 4: load destination register.
- `ld_data_i` in 32: load return data.
- `ld_rdy_o` out 1: load return accepted when `ld_vld_i && ld_rdy_o`.
- `wp_we_o` out 1: register-file write enable.
- `wp_addr_o` out 4: register-file write address.
- `wp_data_o` out 32: register-file write data.
- `pend_o` out 16: one-hot OR of destinations of valid buffered loads.

## Operation

- State: FIFO of DEPTH entries `{vld, addr[3:0], data[31:0]}`, read/write pointers, count (0..DEPTH).
- `ld_rdy_o = (count < DEPTH)`; it depends on the registered count only, with no same-cycle pop credit.
- Grant rules, evaluated in this order each cycle:
  - **Full and ex write** (count==DEPTH, `ex_we_i`): pop the head and write it if its `vld` is set. `ex_stall_o`=1. No kill. No enqueue, because `ld_rdy_o`=0.
  - **Ex write, not full**: write `ex_addr_i`/`ex_data_i`. `ex_stall_o`=0.
    - Every buffered entry with addr==`ex_addr_i` gets `vld` cleared (kill).
    - An accepted load this cycle with `ld_addr_i`==`ex_addr_i` is dropped and not enqueued; it is older.
    - Any other accepted load is enqueued.
  - **No ex write, count>0**: pop the head. Write it if `vld`; otherwise `wp_we_o`=0 (bubble). An accepted load is enqueued.
  - **No ex write, count==0**: an accepted load bypasses and is written directly. Nothing is enqueued.
- Push and pop may occur in the same cycle; count is unchanged.
- Pointers wrap modulo DEPTH.
- Killed entries still occupy slots until popped.
- `pend_o` is built from registered FIFO state. It does not include the current-cycle bypass or enqueue.
- When `reset` is low, outputs are forced: `wp_we_o`=0, `ex_stall_o`=0, `ld_rdy_o`=0.

## Timing

- Reset (asynchronous assert, synchronous release): count=0, pointers=0, all `vld`=0, `pend_o`=0.
  - First cycle after release: `ld_rdy_o`=1, `ex_stall_o`=0.
- `wp_*` and `ex_stall_o` are combinational from inputs and state. The register file samples them on the same edge.
- Load latency to write port:
  - 0 cycles when bypassing.
  - Otherwise written on the first non-ex cycle after all older entries drain, or forced out by a full stall.
- Execute write latency is 0 cycles when granted. A stall lasts exactly until the cycle after one pop.
- Reset mid-operation discards all buffered loads. No write is issued.
- `ex_we_i` with the same address as a granted head pop: only the pop writes that cycle (full case). The ex write is retried next cycle and wins.

## Test plan

- **Bypass:** empty; `ld_vld_i`=1, addr 3, data 0xDEADBEEF, `ex_we_i`=0.
  - Same cycle: `wp_we_o`=1, addr 3, data 0xDEADBEEF. count stays 0.
- **Collision buffering:** `ex_we_i` addr 1 data 0x11 together with load addr 2 data 0x22.
  - Cycle 0: writes r1=0x11; `pend_o`=0x0004 next cycle.
  - Cycle 1, ex idle: writes r2=0x22; `pend_o`=0.
- **Full stall:** DEPTH=2; fill with loads r4=0x44, r5=0x55 under continuous ex writes r6.
  - Then `ld_rdy_o`=0.
  - Next ex write r7: `ex_stall_o`=1, wp writes r4=0x44.
  - Following cycle: r7 granted; `ex_stall_o`=0.
- **Kill:** buffer holds load r8=0x88; ex writes r8=0x99.
  - r8 entry is cleared; `pend_o` bit 8 drops.
  - Next idle cycle: `wp_we_o`=0 bubble.
  - Final r8=0x99.
- **Same-cycle kill of incoming load:** ex write r9=0x1 with accepted load r9=0x2.
  - `ld_rdy_o`=1, load dropped, count unchanged, r9=0x1.
- **Wrap and reset:** stream 10 loads with ex writes on alternate cycles.
  - Writes occur in issue order across pointer wrap.
  - Assert `reset` with 2 entries pending: `wp_we_o`=0 immediately; `pend_o`=0. After release, count=0.

Source files
------------

// File: rtl/hs32_wb_arbiter.sv
// hs32_wb_arbiter: arbitrates the single register-file write port between the
// execute stage (priority) and load returns. Loads that lose arbitration wait in
// an in-order skid FIFO that drains on write-port cycles the execute stage does
// not use. A younger execute write to the same register cancels buffered loads.
//
// Ports:
//   clk, reset               core clock, asynchronous active-low reset
//   ex_we_i/addr_i/data_i    execute write request
//   ex_stall_o               execute write not granted this cycle
//   ld_vld_i/addr_i/data_i   load return, accepted when ld_vld_i && ld_rdy_o
//   ld_rdy_o                 load buffer has a free slot
//   wp_we_o/addr_o/data_o    register-file write port (combinational)
//   pend_o                   one-hot OR of valid buffered load destinations
module hs32_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_we_i,
  input  logic [3:0]  ex_addr_i,
  input  logic [31:0] ex_data_i,
  output logic        ex_stall_o,
  input  logic        ld_vld_i,
  input  logic [3:0]  ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_rdy_o,
  output logic        wp_we_o,
  output logic [3:0]  wp_addr_o,
  output logic [31:0] wp_data_o,
  output logic [15:0] pend_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic        vld;
    logic [3:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic   full;
  logic   empty;
  logic   accept;
  logic   push;
  logic   pop;
  logic   kill;
  entry_t head;

  assign head     = fifo_q[rd_ptr_q];
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  // Readiness comes from the registered count only; a same-cycle pop does not free a slot.
  assign ld_rdy_o = reset & ~full;
  assign accept   = ld_vld_i & ld_rdy_o;

  // Write-port grant and FIFO control.
  always_comb begin
    wp_we_o    = 1'b0;
    wp_addr_o  = '0;
    wp_data_o  = '0;
    ex_stall_o = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    kill       = 1'b0;
    if (ex_we_i && full) begin
      // Full buffer must make progress: head wins, execute retries next cycle.
      pop        = 1'b1;
      ex_stall_o = 1'b1;
      if (head.vld) begin
        wp_we_o   = 1'b1;
        wp_addr_o = head.addr;
        wp_data_o = head.data;
      end
    end else if (ex_we_i) begin
      wp_we_o   = 1'b1;
      wp_addr_o = ex_addr_i;
      wp_data_o = ex_data_i;
      kill      = 1'b1;
      // An incoming load to the same register is older than this write: drop it.
      push      = accept && (ld_addr_i != ex_addr_i);
    end else if (!empty) begin
      pop  = 1'b1;
      push = accept;
      if (head.vld) begin
        wp_we_o   = 1'b1;
        wp_addr_o = head.addr;
        wp_data_o = head.data;
      end
    end else if (accept) begin
      wp_we_o   = 1'b1;
      wp_addr_o = ld_addr_i;
      wp_data_o = ld_data_i;
    end
    if (!reset) begin
      wp_we_o    = 1'b0;
      ex_stall_o = 1'b0;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[PW'(i)] <= '0;
      end
    end else begin
      if (kill) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (fifo_q[PW'(i)].addr == ex_addr_i) begin
            fifo_q[PW'(i)].vld <= 1'b0;
          end
        end
      end
      // Popped slots are invalidated so pend_o only reflects occupied entries.
      if (pop) begin
        fifo_q[rd_ptr_q].vld <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {1'b1, ld_addr_i, ld_data_i};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Pending-destination mask from registered FIFO state.
  always_comb begin
    pend_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_q[PW'(i)].vld) begin
        pend_o[fifo_q[PW'(i)].addr] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs32_wb_arbiter.sv
// Self-checking bench for hs32_wb_arbiter: directed scenarios with fixed
// expectations plus queue-based reference model for streamed/random traffic.
module tb_hs32_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_we;
  logic [3:0]  ex_addr;
  logic [31:0] ex_data;
  logic        ex_stall;
  logic        ld_vld;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_rdy;
  logic        wp_we;
  logic [3:0]  wp_addr;
  logic [31:0] wp_data;
  logic [15:0] pend;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [16];

  typedef struct {
    bit          vld;
    logic [3:0]  addr;
    logic [31:0] data;
  } ment_t;
  ment_t mq[$];

  hs32_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_we_i    (ex_we),
    .ex_addr_i  (ex_addr),
    .ex_data_i  (ex_data),
    .ex_stall_o (ex_stall),
    .ld_vld_i   (ld_vld),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .ld_rdy_o   (ld_rdy),
    .wp_we_o    (wp_we),
    .wp_addr_o  (wp_addr),
    .wp_data_o  (wp_data),
    .pend_o     (pend)
  );

  always #5 clk = ~clk;

  // Shadow register file fed by the write port.
  always @(posedge clk) begin
    if (wp_we) rf[wp_addr] <= wp_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs after the falling edge, settle, return.
  task automatic drive(input logic ew, input logic [3:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [3:0] la, input logic [31:0] ldat);
    @(negedge clk);
    ex_we = ew; ex_addr = ea; ex_data = ed;
    ld_vld = lv; ld_addr = la; ld_data = ldat;
    #1;
  endtask

  // Reference: in-order queue of buffered loads; returns this cycle's expected
  // outputs (from pre-edge state) and advances the queue to post-edge state.
  task automatic model_step(input logic ew, input logic [3:0] ea, input logic [31:0] ed,
                            input logic lv, input logic [3:0] la, input logic [31:0] ldat,
                            output logic e_we, output logic [3:0] e_addr,
                            output logic [31:0] e_data, output logic e_stall,
                            output logic e_rdy, output logic [15:0] e_pend);
    ment_t h;
    logic  acc;
    e_we = 1'b0; e_addr = '0; e_data = '0; e_stall = 1'b0;
    e_rdy = (mq.size() < DEPTH);
    e_pend = '0;
    foreach (mq[i]) if (mq[i].vld) e_pend[mq[i].addr] = 1'b1;
    acc = lv && e_rdy;
    if (ew && mq.size() == DEPTH) begin
      h = mq.pop_front();
      e_stall = 1'b1;
      e_we = h.vld; e_addr = h.addr; e_data = h.data;
    end else if (ew) begin
      e_we = 1'b1; e_addr = ea; e_data = ed;
      foreach (mq[i]) if (mq[i].addr == ea) mq[i].vld = 1'b0;
      if (acc && la != ea) mq.push_back('{1'b1, la, ldat});
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e_we = h.vld; e_addr = h.addr; e_data = h.data;
      if (acc) mq.push_back('{1'b1, la, ldat});
    end else if (acc) begin
      e_we = 1'b1; e_addr = la; e_data = ldat;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    ex_we = 1'b1; ex_addr = 4'd5; ex_data = 32'h5;
    ld_vld = 1'b1; ld_addr = 4'd6; ld_data = 32'h6;
    #1;
    checks++; if (wp_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", wp_we); end
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", ex_stall); end
    checks++; if (ld_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", ld_rdy); end
    checks++; if (pend !== 16'h0) begin errors++; $display("FAIL reset_pend got=%h exp=0000", pend); end
    @(negedge clk);
    reset = 1'b1;
    ex_we = 1'b0; ld_vld = 1'b0;
    #1;
    checks++; if (ld_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy got=%b exp=1", ld_rdy); end
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL release_stall got=%b exp=0", ex_stall); end
    checks++; if (wp_we !== 1'b0) begin errors++; $display("FAIL release_we got=%b exp=0", wp_we); end
  endtask

  task automatic test_bypass();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'hDEADBEEF);
    checks++; if (wp_we !== 1'b1) begin errors++; $display("FAIL bypass_we got=%b exp=1", wp_we); end
    checks++; if (wp_addr !== 4'd3) begin errors++; $display("FAIL bypass_addr got=%h exp=3", wp_addr); end
    checks++; if (wp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data got=%h exp=deadbeef", wp_data); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (wp_we !== 1'b0) begin errors++; $display("FAIL bypass_empty_we got=%b exp=0", wp_we); end
    checks++; if (pend !== 16'h0) begin errors++; $display("FAIL bypass_pend got=%h exp=0000", pend); end
    checks++; if (rf[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rf got=%h exp=deadbeef", rf[3]); end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    checks++; if (wp_we !== 1'b1 || wp_addr !== 4'd1 || wp_data !== 32'h11) begin
      errors++; $display("FAIL coll_ex got=%b/%h/%h exp=1/1/00000011", wp_we, wp_addr, wp_data); end
    checks++; if (ex_stall !== 1'b0 || ld_rdy !== 1'b1) begin
      errors++; $display("FAIL coll_hs got=stall%b rdy%b exp=stall0 rdy1", ex_stall, ld_rdy); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (pend !== 16'h0004) begin errors++; $display("FAIL coll_pend got=%h exp=0004", pend); end
    checks++; if (wp_we !== 1'b1 || wp_addr !== 4'd2 || wp_data !== 32'h22) begin
      errors++; $display("FAIL coll_drain got=%b/%h/%h exp=1/2/00000022", wp_we, wp_addr, wp_data); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (pend !== 16'h0 || wp_we !== 1'b0) begin
      errors++; $display("FAIL coll_idle got=pend%h we%b exp=pend0000 we0", pend, wp_we); end
  endtask

  task automatic test_full_stall();
    drive(1'b1, 4'd6, 32'h66, 1'b1, 4'd4, 32'h44);
    drive(1'b1, 4'd6, 32'h66, 1'b1, 4'd5, 32'h55);
    checks++; if (ld_rdy !== 1'b1 || wp_addr !== 4'd6) begin
      errors++; $display("FAIL fill_second got=rdy%b addr%h exp=rdy1 addr6", ld_rdy, wp_addr); end
    drive(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
    checks++; if (ld_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got=%b exp=0", ld_rdy); end
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", ex_stall); end
    checks++; if (wp_we !== 1'b1 || wp_addr !== 4'd4 || wp_data !== 32'h44) begin
      errors++; $display("FAIL full_pop got=%b/%h/%h exp=1/4/00000044", wp_we, wp_addr, wp_data); end
    checks++; if (pend !== 16'h0030) begin errors++; $display("FAIL full_pend got=%h exp=0030", pend); end
    drive(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
    checks++; if (ex_stall !== 1'b0 || wp_we !== 1'b1 || wp_addr !== 4'd7 || wp_data !== 32'h77) begin
      errors++; $display("FAIL retry_grant got=stall%b %b/%h/%h exp=stall0 1/7/00000077", ex_stall, wp_we, wp_addr, wp_data); end
    checks++; if (pend !== 16'h0020 || ld_rdy !== 1'b1) begin
      errors++; $display("FAIL retry_state got=pend%h rdy%b exp=pend0020 rdy1", pend, ld_rdy); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (wp_we !== 1'b1 || wp_addr !== 4'd5 || wp_data !== 32'h55) begin
      errors++; $display("FAIL full_drain got=%b/%h/%h exp=1/5/00000055", wp_we, wp_addr, wp_data); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (wp_we !== 1'b0 || pend !== 16'h0) begin
      errors++; $display("FAIL full_empty got=we%b pend%h exp=we0 pend0000", wp_we, pend); end
  endtask

  task automatic test_kill();
    drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd8, 32'h88);
    drive(1'b1, 4'd8, 32'h99, 1'b0, 4'd0, 32'h0);
    checks++; if (pend !== 16'h0100) begin errors++; $display("FAIL kill_pend_before got=%h exp=0100", pend); end
    checks++; if (wp_we !== 1'b1 || wp_addr !== 4'd8 || wp_data !== 32'h99 || ex_stall !== 1'b0) begin
      errors++; $display("FAIL kill_ex got=%b/%h/%h stall%b exp=1/8/00000099 stall0", wp_we, wp_addr, wp_data, ex_stall); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (pend !== 16'h0) begin errors++; $display("FAIL kill_pend_after got=%h exp=0000", pend); end
    checks++; if (wp_we !== 1'b0) begin errors++; $display("FAIL kill_bubble got=%b exp=0", wp_we); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (rf[8] !== 32'h99 || wp_we !== 1'b0) begin
      errors++; $display("FAIL kill_final got=r8=%h we%b exp=r8=00000099 we0", rf[8], wp_we); end
  endtask

  task automatic test_same_cycle_kill();
    drive(1'b1, 4'd9, 32'h1, 1'b1, 4'd9, 32'h2);
    checks++; if (ld_rdy !== 1'b1) begin errors++; $display("FAIL sck_rdy got=%b exp=1", ld_rdy); end
    checks++; if (wp_we !== 1'b1 || wp_addr !== 4'd9 || wp_data !== 32'h1) begin
      errors++; $display("FAIL sck_write got=%b/%h/%h exp=1/9/00000001", wp_we, wp_addr, wp_data); end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checks++; if (wp_we !== 1'b0 || pend !== 16'h0 || ld_rdy !== 1'b1) begin
      errors++; $display("FAIL sck_dropped got=we%b pend%h rdy%b exp=we0 pend0000 rdy1", wp_we, pend, ld_rdy); end
    checks++; if (rf[9] !== 32'h1) begin errors++; $display("FAIL sck_rf got=%h exp=00000001", rf[9]); end
  endtask

  task automatic test_wrap_reset();
    logic        e_we, e_stall, e_rdy;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic [15:0] e_pend;
    logic        ew, lv;
    logic [3:0]  la;
    logic [31:0] ed, ldat;
    int j = 0;
    int written = 0;
    mq.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      lv   = (j < 10);
      ew   = (j < 10) && (cyc % 2 == 0);
      ed   = 32'hE000 + 32'(cyc);
      la   = 4'(8 + (j % 8));
      ldat = 32'hA000 + 32'(j);
      drive(ew, 4'd1, ed, lv, la, ldat);
      model_step(ew, 4'd1, ed, lv, la, ldat, e_we, e_addr, e_data, e_stall, e_rdy, e_pend);
      checks++; if (wp_we !== e_we) begin errors++; $display("FAIL wrap_we cyc=%0d got=%b exp=%b", cyc, wp_we, e_we); end
      if (e_we) begin
        checks++; if (wp_addr !== e_addr || wp_data !== e_data) begin
          errors++; $display("FAIL wrap_wdata cyc=%0d got=%h/%h exp=%h/%h", cyc, wp_addr, wp_data, e_addr, e_data); end
      end
      checks++; if (ex_stall !== e_stall || ld_rdy !== e_rdy || pend !== e_pend) begin
        errors++; $display("FAIL wrap_ctl cyc=%0d got=stall%b rdy%b pend%h exp=stall%b rdy%b pend%h",
                           cyc, ex_stall, ld_rdy, pend, e_stall, e_rdy, e_pend); end
      if (wp_we && wp_addr[3]) begin
        checks++; if (wp_data !== 32'hA000 + 32'(written)) begin
          errors++; $display("FAIL wrap_order got=%h exp=%h", wp_data, 32'hA000 + 32'(written)); end
        written++;
      end
      if (lv && e_rdy) j++;
    end
    checks++; if (j != 10 || written != 10) begin
      errors++; $display("FAIL wrap_count got=accepted%0d written%0d exp=10/10", j, written); end
    drive(1'b1, 4'd1, 32'hE1, 1'b1, 4'd12, 32'hB0);
    drive(1'b1, 4'd1, 32'hE2, 1'b1, 4'd13, 32'hB1);
    checks++; if (pend !== 16'h1000) begin errors++; $display("FAIL wrap_prereset_pend got=%h exp=1000", pend); end
    @(negedge clk);
    reset = 1'b0;
    ex_we = 1'b1; ld_vld = 1'b1;
    #1;
    checks++; if (wp_we !== 1'b0 || pend !== 16'h0 || ld_rdy !== 1'b0 || ex_stall !== 1'b0) begin
      errors++; $display("FAIL midreset got=we%b pend%h rdy%b stall%b exp=we0 pend0000 rdy0 stall0", wp_we, pend, ld_rdy, ex_stall); end
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
    ex_we = 1'b0; ld_vld = 1'b0;
    #1;
    checks++; if (wp_we !== 1'b0 || pend !== 16'h0 || ld_rdy !== 1'b1) begin
      errors++; $display("FAIL postreset got=we%b pend%h rdy%b exp=we0 pend0000 rdy1", wp_we, pend, ld_rdy); end
  endtask

  task automatic test_random();
    logic        e_we, e_stall, e_rdy;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic [15:0] e_pend;
    logic        ew, lv;
    logic [3:0]  ea, la;
    logic [31:0] ed, ldat;
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      ew   = 1'($urandom_range(0, 1));
      ea   = 4'($urandom_range(0, 3));
      ed   = $urandom;
      lv   = ($urandom_range(0, 9) < 6);
      la   = 4'($urandom_range(0, 3));
      ldat = $urandom;
      drive(ew, ea, ed, lv, la, ldat);
      model_step(ew, ea, ed, lv, la, ldat, e_we, e_addr, e_data, e_stall, e_rdy, e_pend);
      checks++; if (wp_we !== e_we) begin errors++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", cyc, wp_we, e_we); end
      if (e_we) begin
        checks++; if (wp_addr !== e_addr || wp_data !== e_data) begin
          errors++; $display("FAIL rand_wdata cyc=%0d got=%h/%h exp=%h/%h", cyc, wp_addr, wp_data, e_addr, e_data); end
      end
      checks++; if (ex_stall !== e_stall || ld_rdy !== e_rdy || pend !== e_pend) begin
        errors++; $display("FAIL rand_ctl cyc=%0d got=stall%b rdy%b pend%h exp=stall%b rdy%b pend%h",
                           cyc, ex_stall, ld_rdy, pend, e_stall, e_rdy, e_pend); end
    end
  endtask

  initial begin
    reset = 1'b0;
    ex_we = 1'b0; ex_addr = '0; ex_data = '0;
    ld_vld = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_bypass();
    test_collision();
    test_full_stall();
    test_kill();
    test_same_cycle_kill();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
